regfile_clear_sequencer: RTL and testbench

//  Controller that owns the register-file write port during a bulk clear.
//  On a start pulse it writes the constant 32'h0000_0000 to every register, one per cycle.
//  It also arbitrates that write port between itself and the CPU writeback path.

---
 rtl/regfile_clear_sequencer_pkg.sv | 17 +
 rtl/regclr_index_counter.sv | 38 +++
 rtl/regfile_clear_sequencer.sv | 134 +++++++++++++
 tb/tb_regfile_clear_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_clear_sequencer_pkg.sv
// Shared definitions for the register-file clear sequencer:
// state encoding and the constant word written during a clear.
package regfile_clear_sequencer_pkg;

   // Sequencer states; encoding is fixed so debug views match across builds
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Word written into every cleared register
   function automatic logic [63:0] zero_word();
      return 64'h0000_0000_0000_0000;
   endfunction

endpackage

// File: rtl/regclr_index_counter.sv
// Loadable, enable-gated register index counter for the clear sequencer.
// Flags the last architectural register so the sequencer can stop without
// letting the index wrap.
module regclr_index_counter #(
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              en,
   output logic [ADDR_W-1:0] idx,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

   logic [ADDR_W-1:0] idx_r;

   // Index register: load wins over increment, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= {ADDR_W{1'b0}};
      end else if (load) begin
         idx_r <= load_val;
      end else if (en) begin
         idx_r <= idx_r + ONE_IDX;
      end else begin
         idx_r <= idx_r;
      end
   end

   assign idx  = idx_r;
   assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/regfile_clear_sequencer.sv
// Register-file clear sequencer: owns the register-file write port while
// zeroing registers START_REG..NUM_REGS-1, one per cycle, and otherwise
// passes the CPU writeback path straight through.
// Optional build macro REGCLR_CPU_PRIORITY_EN: when defined, a CPU write
// during a clear takes the port for that cycle and the clear index holds;
// when undefined, the CPU is stalled for the whole clear.
module regfile_clear_sequencer
   import regfile_clear_sequencer_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int START_REG = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              cpu_stall,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_wa,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd
);

   localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(zero_word());
   localparam logic [ADDR_W-1:0] START_IDX = ADDR_W'(START_REG);

   // Elaboration-time guards on illegal configurations
   generate
      if (START_REG >= NUM_REGS) begin : g_bad_start_reg
         $error("regfile_clear_sequencer: START_REG must be below NUM_REGS");
      end
      if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
         $error("regfile_clear_sequencer: ADDR_W too narrow for NUM_REGS");
      end
   endgenerate

   state_t            state_r;
   logic [ADDR_W-1:0] idx_s;
   logic              last_s;
   logic              load_s;
   logic              adv_s;
   logic              preempt_s;

`ifdef REGCLR_CPU_PRIORITY_EN
   assign preempt_s = (state_r == S_CLEAR) && cpu_we;
`else
   assign preempt_s = 1'b0;
`endif

   assign load_s = (state_r == S_IDLE) && start;
   // Stop advancing on the last register so the index never wraps
   assign adv_s  = (state_r == S_CLEAR) && !preempt_s && !last_s;

   regclr_index_counter #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_index_counter (
      .clk      (clk),
      .rst_n    (reset),
      .load     (load_s),
      .load_val (START_IDX),
      .en       (adv_s),
      .idx      (idx_s),
      .last     (last_s)
   );

   // Sequencer state machine: IDLE -> CLEAR -> DONE -> IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  state_r <= S_CLEAR;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_CLEAR: begin
               if (!preempt_s && last_s) begin
                  state_r <= S_DONE;
               end else begin
                  state_r <= S_CLEAR;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Write-port mux and status outputs, decoded from state, index and CPU path
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      cpu_stall = 1'b0;
      rf_we     = cpu_we;
      rf_wa     = cpu_wa;
      rf_wd     = cpu_wd;
      case (state_r)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_CLEAR: begin
            busy = 1'b1;
            if (preempt_s) begin
               cpu_stall = 1'b0;
            end else begin
               rf_we     = 1'b1;
               rf_wa     = idx_s;
               rf_wd     = ZERO_WORD;
               cpu_stall = cpu_we;
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_clear_sequencer.sv
// Directed self-checking bench for regfile_clear_sequencer (default parameters).
module tb_regfile_clear_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        cpu_stall;
   logic        cpu_we;
   logic [4:0]  cpu_wa;
   logic [31:0] cpu_wd;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   int checks;
   int errors;
   int done_cnt;
   int idx_exp;

   regfile_clear_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .cpu_stall (cpu_stall),
      .cpu_we    (cpu_we),
      .cpu_wa    (cpu_wa),
      .cpu_wd    (cpu_wd),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge (input drive point)
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // wait to the falling edge (output sample point)
   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      done_cnt = 0;
      // reset values with CPU path passing through
      reset = 1'b0; start = 1'b0;
      cpu_we = 1'b1; cpu_wa = 5'd3; cpu_wd = 32'h0000_0123;
      #2;
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_stall", cpu_stall, 32'd0);
      chk("rst_rf_we", rf_we, 32'd1);
      chk("rst_rf_wa", rf_wa, 32'd3);
      next(); next();
      reset = 1'b1; cpu_we = 1'b0;

      // idle passthrough
      cpu_we = 1'b1; cpu_wa = 5'd7; cpu_wd = 32'hDEAD_BEEF;
      settle();
      chk("idle_rf_we", rf_we, 32'd1);
      chk("idle_rf_wa", rf_wa, 32'd7);
      chk("idle_rf_wd", rf_wd, 32'hDEAD_BEEF);
      chk("idle_stall", cpu_stall, 32'd0);
      next();

      // full clear, no CPU traffic
      cpu_we = 1'b0; start = 1'b1;
      settle();
      chk("start_busy", busy, 32'd0);
      next();
      start = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         settle();
         chk($sformatf("clr_busy_%0d", i), busy, 32'd1);
         chk($sformatf("clr_we_%0d", i), rf_we, 32'd1);
         chk($sformatf("clr_wa_%0d", i), rf_wa, 32'(i));
         chk($sformatf("clr_wd_%0d", i), rf_wd, 32'd0);
         chk($sformatf("clr_done_%0d", i), done, 32'd0);
         next();
      end
      settle();
      chk("end_done", done, 32'd1);
      chk("end_busy", busy, 32'd0);
      next();
      settle();
      chk("post_done", done, 32'd0);
      next();

`ifndef REGCLR_CPU_PRIORITY_EN
      // CPU write contends with the clear: CPU stalled, port stays with clear
      start = 1'b1; cpu_we = 1'b1; cpu_wa = 5'd9; cpu_wd = 32'h0000_0055;
      settle();
      chk("both_rf_wa", rf_wa, 32'd9);
      chk("both_rf_wd", rf_wd, 32'h55);
      chk("both_stall", cpu_stall, 32'd0);
      next();
      for (int i = 1; i <= 31; i++) begin
         start = (i == 5) ? 1'b1 : 1'b0;
         settle();
         chk($sformatf("cont_stall_%0d", i), cpu_stall, 32'd1);
         chk($sformatf("cont_wd_%0d", i), rf_wd, 32'd0);
         chk($sformatf("cont_wa_%0d", i), rf_wa, 32'(i));
         next();
      end
      start = 1'b0;
      settle();
      chk("cont_done", done, 32'd1);
      chk("cont_cpu_wa", rf_wa, 32'd9);
      chk("cont_cpu_wd", rf_wd, 32'h55);
      chk("cont_cpu_stall", cpu_stall, 32'd0);
      next();
      cpu_we = 1'b0;
      settle();
      chk("cont_idle_busy", busy, 32'd0);
      chk("cont_idle_done", done, 32'd0);
      next();
`else
      // CPU preempts three clear cycles; clear stretches by three
      start = 1'b1; cpu_we = 1'b0; cpu_wa = 5'd9; cpu_wd = 32'h0000_0055;
      next();
      start = 1'b0;
      idx_exp = 1;
      for (int c = 0; c < 34; c++) begin
         cpu_we = (c >= 3 && c < 6) ? 1'b1 : 1'b0;
         settle();
         chk($sformatf("pri_busy_%0d", c), busy, 32'd1);
         chk($sformatf("pri_stall_%0d", c), cpu_stall, 32'd0);
         if (cpu_we) begin
            chk($sformatf("pri_cpu_wd_%0d", c), rf_wd, 32'h55);
            chk($sformatf("pri_cpu_wa_%0d", c), rf_wa, 32'd9);
         end else begin
            chk($sformatf("pri_clr_wa_%0d", c), rf_wa, 32'(idx_exp));
            chk($sformatf("pri_clr_wd_%0d", c), rf_wd, 32'd0);
            idx_exp++;
         end
         next();
      end
      cpu_we = 1'b0;
      settle();
      chk("pri_done", done, 32'd1);
      next();
`endif

      // abort at idx 10 by reset, then restart
      start = 1'b1;
      next();
      start = 1'b0;
      for (int i = 1; i < 10; i++) next();
      settle();
      chk("abort_pre_wa", rf_wa, 32'd10);
      reset = 1'b0; cpu_we = 1'b1; cpu_wa = 5'd4; cpu_wd = 32'h0000_0077;
      #1;
      chk("abort_busy", busy, 32'd0);
      chk("abort_stall", cpu_stall, 32'd0);
      chk("abort_rf_we", rf_we, 32'd1);
      chk("abort_rf_wa", rf_wa, 32'd4);
      next();
      reset = 1'b1; cpu_we = 1'b0;
      next();
      settle();
      chk("abort_no_done", done, 32'd0);
      chk("abort_idle_busy", busy, 32'd0);
      next();
      start = 1'b1;
      next();
      for (int c = 0; c < 40; c++) begin
         start = (c == 2) ? 1'b1 : 1'b0;
         settle();
         if (c < 31) begin
            chk($sformatf("rs_wa_%0d", c), rf_wa, 32'(c + 1));
            chk($sformatf("rs_busy_%0d", c), busy, 32'd1);
         end
         if (done) done_cnt++;
         next();
      end
      start = 1'b0;
      chk("rs_done_count", 32'(done_cnt), 32'd1);
      chk("rs_final_busy", busy, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
